// File: rtl/rf_pkg.sv
// Shared register-file constants and types for the write-back path.
package rf_pkg;

   localparam int unsigned NREG      = 32;
   localparam int unsigned AW        = 5;
   localparam int unsigned DW        = 32;
   localparam int unsigned N_REQ_DEF = 3;

   typedef logic [AW-1:0] rf_addr_t;
   typedef logic [DW-1:0] rf_data_t;

endpackage : rf_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after i_ptr wins.
module rr_arbiter #(
   parameter int unsigned N  = 3,
   parameter int unsigned PW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt_c,
   output logic [PW-1:0] o_gnt_idx_c
);

   logic          w_found;
   logic [PW:0]   w_sum;
   logic [PW-1:0] w_k;

   // Walk the requesters starting at i_ptr, wrapping modulo N, and grant the first valid one
   always_comb begin
      o_gnt_c     = '0;
      o_gnt_idx_c = '0;
      w_found     = 1'b0;
      w_sum       = '0;
      w_k         = '0;
      for (int unsigned i = 0; i < N; i++) begin
         w_sum = {1'b0, i_ptr} + (PW+1)'(i);
         if (w_sum >= (PW+1)'(N)) begin
            w_sum = w_sum - (PW+1)'(N);
         end
         w_k = w_sum[PW-1:0];
         if (!w_found && i_req[w_k]) begin
            w_found       = 1'b1;
            o_gnt_c[w_k]  = 1'b1;
            o_gnt_idx_c   = w_k;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with a pending-write scoreboard for hazard detection.
module rf_wb_arbiter
   import rf_pkg::*;
#(
   parameter int unsigned N_REQ = rf_pkg::N_REQ_DEF,
   parameter int unsigned AW    = rf_pkg::AW,
   parameter int unsigned DW    = rf_pkg::DW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]    i_req_valid,
   input  logic [N_REQ*AW-1:0] i_req_addr,
   input  logic [N_REQ*DW-1:0] i_req_data,
   output logic [N_REQ-1:0]    o_req_ready_c,
   output logic               o_rf_wr,
   output logic [AW-1:0]      o_rf_a3,
   output logic [DW-1:0]      o_rf_wd,
   input  logic               i_issue_valid,
   input  logic [AW-1:0]      i_issue_addr,
   input  logic [AW-1:0]      i_chk_a1,
   input  logic [AW-1:0]      i_chk_a2,
   output logic               o_busy1_c,
   output logic               o_busy2_c,
   output logic               o_busy_dst_c,
   output logic               o_err
);

   localparam int unsigned PW = $clog2(N_REQ);
   localparam int unsigned NR = 1 << AW;

   logic [PW-1:0]    r_ptr;
   logic             r_rf_wr;
   logic [AW-1:0]    r_rf_a3;
   logic [DW-1:0]    r_rf_wd;
   logic [NR-1:0]    r_busy;
   logic             r_err;

   logic [N_REQ-1:0] w_gnt;
   logic [PW-1:0]    w_idx;
   logic             w_any;
   logic [AW-1:0]    w_addr_arr [N_REQ];
   logic [DW-1:0]    w_data_arr [N_REQ];
   logic [AW-1:0]    w_gaddr;
   logic [DW-1:0]    w_gdata;
   logic [NR-1:0]    w_busy_nxt;
   logic             w_clr_hit;
   logic             w_waw;
   logic             w_unsb;

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign w_addr_arr[g] = i_req_addr[g*AW +: AW];
      assign w_data_arr[g] = i_req_data[g*DW +: DW];
   end

   rr_arbiter #(.N(N_REQ), .PW(PW)) u_rr (
      .i_req       (i_req_valid),
      .i_ptr       (r_ptr),
      .o_gnt_c     (w_gnt),
      .o_gnt_idx_c (w_idx)
   );

   assign w_any         = |w_gnt;
   assign w_gaddr       = w_addr_arr[w_idx];
   assign w_gdata       = w_data_arr[w_idx];
   assign o_req_ready_c = w_gnt;

   // Scoreboard next state: retire the write in flight, then mark the new issue (set wins)
   always_comb begin
      w_busy_nxt = r_busy;
      if (r_rf_wr) begin
         w_busy_nxt[r_rf_a3] = 1'b0;
      end
      if (i_issue_valid) begin
         w_busy_nxt[i_issue_addr] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   // Protocol checks: re-issue of a still-pending register, or a write nobody scoreboarded
   always_comb begin
      w_clr_hit = r_rf_wr && (r_rf_a3 == i_issue_addr);
      w_waw     = i_issue_valid && (i_issue_addr != '0) && r_busy[i_issue_addr] && !w_clr_hit;
      w_unsb    = w_any && (w_gaddr != '0) && !r_busy[w_gaddr];
   end

   // Pointer, output stage, scoreboard and sticky error registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr   <= '0;
         r_rf_wr <= 1'b0;
         r_rf_a3 <= '0;
         r_rf_wd <= '0;
         r_busy  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_rf_wr <= w_any && (w_gaddr != '0);
         if (w_any) begin
            r_ptr   <= (w_idx == PW'(N_REQ - 1)) ? '0 : PW'(w_idx + PW'(1));
            r_rf_a3 <= w_gaddr;
            r_rf_wd <= w_gdata;
         end
         r_busy <= w_busy_nxt;
         r_err  <= r_err | w_waw | w_unsb;
      end
   end

   assign o_rf_wr      = r_rf_wr;
   assign o_rf_a3      = r_rf_a3;
   assign o_rf_wd      = r_rf_wd;
   assign o_err        = r_err;
   assign o_busy1_c    = r_busy[i_chk_a1];
   assign o_busy2_c    = r_busy[i_chk_a2];
   assign o_busy_dst_c = r_busy[i_issue_addr];

endmodule : rf_wb_arbiter

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;
   import rf_pkg::*;

   localparam int unsigned N = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic           rf_wr;
   rf_addr_t       rf_a3;
   rf_data_t       rf_wd;
   logic           issue_valid;
   rf_addr_t       issue_addr;
   rf_addr_t       chk_a1;
   rf_addr_t       chk_a2;
   logic           busy1;
   logic           busy2;
   logic           busy_dst;
   logic           err;

   int checks   = 0;
   int failures = 0;

   rf_wb_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_req_valid   (req_valid),
      .i_req_addr    (req_addr),
      .i_req_data    (req_data),
      .o_req_ready_c (req_ready),
      .o_rf_wr       (rf_wr),
      .o_rf_a3       (rf_a3),
      .o_rf_wd       (rf_wd),
      .i_issue_valid (issue_valid),
      .i_issue_addr  (issue_addr),
      .i_chk_a1      (chk_a1),
      .i_chk_a2      (chk_a2),
      .o_busy1_c     (busy1),
      .o_busy2_c     (busy2),
      .o_busy_dst_c  (busy_dst),
      .o_err         (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic v, input rf_addr_t a, input rf_data_t d);
      req_valid[k]         = v;
      req_addr[k*AW +: AW] = a;
      req_data[k*DW +: DW] = d;
   endtask

   task automatic do_issue(input rf_addr_t a);
      issue_valid = 1'b1;
      issue_addr  = a;
      tick();
      issue_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
      issue_valid = 1'b0; issue_addr = '0; chk_a1 = '0; chk_a2 = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (rf_wr !== 1'b0) begin failures++; $display("FAIL reset_rf_wr got=%0h exp=0", rf_wr); end
      checks++; if (rf_a3 !== '0) begin failures++; $display("FAIL reset_rf_a3 got=%0h exp=0", rf_a3); end
      checks++; if (rf_wd !== '0) begin failures++; $display("FAIL reset_rf_wd got=%0h exp=0", rf_wd); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", err); end
      checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_ready got=%0h exp=0", req_ready); end
      rst = 1'b0;
      tick();
      chk_a1 = 5'd5;
      issue_valid = 1'b1; issue_addr = 5'd5;
      #1;
      checks++; if (busy_dst !== 1'b0) begin failures++; $display("FAIL idle_busy_dst got=%0h exp=0", busy_dst); end
      tick();
      issue_valid = 1'b0;
      #1;
      checks++; if (busy_dst !== 1'b1) begin failures++; $display("FAIL issue5_busy_dst got=%0h exp=1", busy_dst); end
      checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL issue5_busy1 got=%0h exp=1", busy1); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL issue5_err got=%0h exp=0", err); end
   endtask

   task automatic test_single_write();
      do_issue(5'd3);
      set_req(1, 1'b1, 5'd3, 32'hDEAD_BEEF);
      #1;
      checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL single_ready got=%0h exp=2", req_ready); end
      tick();
      set_req(1, 1'b0, 5'd0, 32'h0);
      chk_a1 = 5'd3;
      #1;
      checks++; if (rf_wr !== 1'b1) begin failures++; $display("FAIL single_rf_wr got=%0h exp=1", rf_wr); end
      checks++; if (rf_a3 !== 5'd3) begin failures++; $display("FAIL single_rf_a3 got=%0h exp=3", rf_a3); end
      checks++; if (rf_wd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rf_wd got=%0h exp=deadbeef", rf_wd); end
      checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL single_busy_t1 got=%0h exp=1", busy1); end
      tick();
      checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL single_busy_t2 got=%0h exp=0", busy1); end
      checks++; if (rf_wr !== 1'b0) begin failures++; $display("FAIL single_rf_wr_t2 got=%0h exp=0", rf_wr); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err got=%0h exp=0", err); end
      // requester 2 retires r5 so the pointer wraps back to 0
      set_req(2, 1'b1, 5'd5, 32'h55);
      #1;
      checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL wrap_ready got=%0h exp=4", req_ready); end
      tick();
      set_req(2, 1'b0, 5'd0, 32'h0);
      checks++; if (rf_a3 !== 5'd5) begin failures++; $display("FAIL wrap_rf_a3 got=%0h exp=5", rf_a3); end
      tick();
   endtask

   task automatic test_round_robin();
      int unsigned k;
      rf_data_t    d;
      for (int b = 0; b < 2; b++) begin
         if (b == 1) begin
            do_issue(5'd4);
            set_req(0, 1'b1, 5'd4, 32'h44);
            #1;
            checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL rr_prep_ready got=%0h exp=1", req_ready); end
            tick();
            set_req(0, 1'b0, 5'd0, 32'h0);
            tick();
         end
         do_issue(5'd1);
         do_issue(5'd2);
         do_issue(5'd3);
         for (int r = 0; r < 3; r++) begin
            set_req(r, 1'b1, rf_addr_t'(r + 1), 32'hA000_0000 + 32'(r) + 32'(16 * b));
         end
         for (int c = 0; c < 3; c++) begin
            k = (b == 0) ? 32'(c) : 32'((c + 1) % 3);
            d = 32'hA000_0000 + k + 32'(16 * b);
            #1;
            checks++; if (req_ready !== 3'(1 << k)) begin failures++; $display("FAIL rr_b%0d_c%0d_ready got=%0h exp=%0h", b, c, req_ready, 3'(1 << k)); end
            tick();
            req_valid[k] = 1'b0;
            checks++; if (rf_wr !== 1'b1 || rf_a3 !== rf_addr_t'(k + 1) || rf_wd !== d) begin
               failures++; $display("FAIL rr_b%0d_c%0d_write got=%0h/%0h/%0h exp=1/%0h/%0h", b, c, rf_wr, rf_a3, rf_wd, k + 1, d);
            end
         end
         tick();
         checks++; if (err !== 1'b0) begin failures++; $display("FAIL rr_b%0d_err got=%0h exp=0", b, err); end
      end
   endtask

   task automatic test_x0();
      set_req(1, 1'b1, 5'd0, 32'h1234);
      #1;
      checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL x0_ready got=%0h exp=2", req_ready); end
      tick();
      set_req(1, 1'b0, 5'd0, 32'h0);
      checks++; if (rf_wr !== 1'b0) begin failures++; $display("FAIL x0_rf_wr got=%0h exp=0", rf_wr); end
      issue_valid = 1'b1; issue_addr = 5'd0;
      #1;
      checks++; if (busy_dst !== 1'b0) begin failures++; $display("FAIL x0_busy_dst_pre got=%0h exp=0", busy_dst); end
      tick();
      issue_valid = 1'b0;
      chk_a1 = 5'd0; chk_a2 = 5'd4;
      #1;
      checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL x0_busy1 got=%0h exp=0", busy1); end
      checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL x0_busy2_r4 got=%0h exp=0", busy2); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL x0_err got=%0h exp=0", err); end
   endtask

   task automatic test_collision();
      do_issue(5'd7);
      set_req(2, 1'b1, 5'd7, 32'h77);
      #1;
      checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL col_ready got=%0h exp=4", req_ready); end
      tick();
      set_req(2, 1'b0, 5'd0, 32'h0);
      issue_valid = 1'b1; issue_addr = 5'd7;
      #1;
      checks++; if (rf_wr !== 1'b1 || rf_a3 !== 5'd7) begin failures++; $display("FAIL col_write got=%0h/%0h exp=1/7", rf_wr, rf_a3); end
      checks++; if (busy_dst !== 1'b1) begin failures++; $display("FAIL col_busy_dst got=%0h exp=1", busy_dst); end
      tick();
      issue_valid = 1'b0;
      chk_a1 = 5'd7;
      #1;
      checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL col_busy7 got=%0h exp=1", busy1); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL col_err got=%0h exp=0", err); end
      set_req(0, 1'b1, 5'd7, 32'h78);
      tick();
      set_req(0, 1'b0, 5'd0, 32'h0);
      tick();
      checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL col_retire7 got=%0h exp=0", busy1); end
   endtask

   task automatic test_error_reset();
      do_issue(5'd9);
      issue_valid = 1'b1; issue_addr = 5'd9;
      #1;
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL waw_err_pre got=%0h exp=0", err); end
      tick();
      issue_valid = 1'b0;
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL waw_err got=%0h exp=1", err); end
      repeat (2) tick();
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL waw_sticky got=%0h exp=1", err); end
      do_issue(5'd10);
      set_req(1, 1'b1, 5'd10, 32'hAA);
      #1;
      checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL err_ready got=%0h exp=2", req_ready); end
      tick();
      set_req(1, 1'b0, 5'd0, 32'h0);
      chk_a1 = 5'd9; chk_a2 = 5'd10;
      #1;
      checks++; if (rf_wr !== 1'b1) begin failures++; $display("FAIL pre_rst_rf_wr got=%0h exp=1", rf_wr); end
      rst = 1'b1;
      #1;
      checks++; if (rf_wr !== 1'b0) begin failures++; $display("FAIL rst_rf_wr got=%0h exp=0", rf_wr); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0h exp=0", err); end
      checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h/%0h exp=0/0", busy1, busy2); end
      checks++; if (rf_a3 !== '0 || rf_wd !== '0) begin failures++; $display("FAIL rst_rf_data got=%0h/%0h exp=0/0", rf_a3, rf_wd); end
      tick();
      rst = 1'b0;
      for (int r = 0; r < 3; r++) set_req(r, 1'b1, 5'd0, 32'h0);
      #1;
      checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL rst_ptr_ready got=%0h exp=1", req_ready); end
      tick();
      req_valid = '0;
      // unscoreboarded write: r12 was never issued
      set_req(1, 1'b1, 5'd12, 32'hC);
      #1;
      checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL unsb_ready got=%0h exp=2", req_ready); end
      tick();
      set_req(1, 1'b0, 5'd0, 32'h0);
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL unsb_err got=%0h exp=1", err); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_round_robin();
      test_x0();
      test_collision();
      test_error_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_rf_wb_arbiter
